alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Sequencing controller wrapped around the 16-bit ALU (`alu`) instance.
- Accepts one operation at a time over a valid/ready command interface and registers the operands.
- Selects the requested ALU output and returns the registered result with status flags over a valid/ready result interface.
- Optionally runs a multi-cycle 16×16 multiply (lower 16 bits) by iterating the ALU adder.
- Sits between the instruction/issue logic and the combinational ALU datapath.

## Interface
Parameters:
- None; the datapath width is fixed at 16 bits by the ALU.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  command valid.
- `in_ready`  out  1  command accepted on an edge where `in_valid & in_ready`.
- `in_op`  in  5  opcode.
- `in_x`  in  16  operand X.
- `in_y`  in  16  operand Y.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed on an edge where `out_valid & out_ready`.
- `out_result`  out  16  result.
- `out_zero`  out  1  `out_result == 0`.
- `out_neg`  out  1  `out_result[15]`.
- `out_err`  out  1  illegal opcode.
- `busy`  out  1  high in any state other than IDLE.

## Operation
States: IDLE, EXEC, MUL, DONE.
- **IDLE:** `in_ready=1`. On accept, latch op, x and y. Op 0–15 or an illegal op goes to EXEC. Op 16, when multiply is compiled in, goes to MUL.
- **EXEC:** the ALU is driven with the latched x and y. The selected output is registered into the result, the flags are set, and the FSM goes to DONE.
- **MUL:** the accumulator starts at 0 and the 4-bit counter `cnt` starts at 0.
  - Each cycle: if `y_lat[cnt]` is set, `acc <= acc + (x_lat << cnt)` (mod 2^16, computed through the ALU adder output `a`).
  - `cnt` increments each cycle.
  - After the `cnt=15` cycle, the FSM goes to DONE with `result = acc`.
- **DONE:** `out_valid=1`. Result and flags are held stable until the handshake. On handshake the FSM goes to IDLE. `in_ready` stays 0 until back in IDLE, so there is no same-cycle re-issue.

Opcode map (ALU output selected):
- 0 `a`: x+y
- 1 `b`: x−y
- 2 `c`: y−x
- 3 `d`: 16'h0001
- 4 `e`: 16'h0000
- 5 `f`: 16'hFFFF
- 6 `g`: −x
- 7 `h`: −y
- 8 `i`: ~x
- 9 `j`: ~y
- 10 `k`: x+1
- 11 `l`: y+1
- 12 `m`: x−1
- 13 `n`: y−1
- 14 `o`: x&y
- 15 `p`: x|y

Arithmetic and flag rules:
- All arithmetic is modulo 2^16; carries and borrows are discarded.
- The 1-bit outputs `d` and `e` are zero-extended.
- Ops 17–31, and op 16 when multiply is compiled out, are illegal: `result=0`, `out_err=1`, `out_zero=1`, and they follow the EXEC latency.
- `out_err=0` for every legal op.

## Timing
- Reset (`rst_n=0` at an edge): FSM to IDLE from any state, including mid-MUL or DONE. A pending result is discarded.
  - Reset values: `in_ready=1`, `out_valid=0`, `out_result=0`, `out_zero=0`, `out_neg=0`, `out_err=0`, `busy=0`.
  - `in_ready=1` is visible on the first cycle after release.
- Single-cycle ops: accept at edge k, EXEC during cycle k→k+1, `out_valid=1` after edge k+1.
- MUL: accept at edge k, iterations on edges k+1..k+16, `out_valid=1` after edge k+16.
- Result consumed at edge m: `out_valid=0` and `in_ready=1` after edge m.
- Minimum issue interval: 3 cycles for single-cycle ops, 18 cycles for MUL.
- `out_ready` held low: `out_valid`, `out_result` and the flags remain constant indefinitely. `in_valid` is ignored.
- `in_x`, `in_y` and `in_op` may change freely after acceptance.

## Configuration
- `ALU_SEQ_MUL_EN` defined: op 16 is multiply as described above; the MUL state, accumulator and counter are present.
- Not defined: no MUL state or registers are built; op 16 is illegal (`out_err=1`, `result=0`, EXEC latency).

## Test plan
- **Add:** op 0, x=16'h1234, y=16'h0FF0 → after edge k+1: `out_result`=16'h2224, `out_zero`=0, `out_neg`=0, `out_err`=0.
- **Reverse subtract:** op 2, x=5, y=3 → `out_result`=16'hFFFE, `out_neg`=1. Then op 4 → 16'h0000 with `out_zero`=1.
- **Multiply (`ALU_SEQ_MUL_EN` defined):** op 16, x=16'h0123, y=16'h0045 → `out_valid` after edge k+16, `out_result`=16'h4E6F. With the macro undefined, the same stimulus gives `out_err`=1, `out_result`=0, after edge k+1.
- **Backpressure:** op 10, x=16'hFFFF, hold `out_ready`=0 for 5 cycles while `in_valid`=1 → result stays 16'h0000 with `out_zero`=1, `in_ready`=0 throughout. Raise `out_ready`: `in_ready`=1 on the next cycle.
- **Illegal op:** op 5'h1F, x=y=16'hAAAA → `out_err`=1, `out_result`=0, `out_zero`=1.
- **Reset mid-operation:** assert `rst_n`=0 for one edge during MUL iteration 7 → all outputs at reset values, `busy`=0, `in_ready`=1 on the first cycle after release. A subsequent op 14 with x=16'hF0F0, y=16'h0FF0 → 16'h00F0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Valid/ready sequencer around a combinational 16-bit ALU; optional iterative multiply (op 16).
// Build option: define ALU_SEQ_MUL_EN to include the MUL state, accumulator and bit counter.
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [15:0] c,
  output logic [15:0] d,
  output logic [15:0] e,
  output logic [15:0] f,
  output logic [15:0] g,
  output logic [15:0] h,
  output logic [15:0] i,
  output logic [15:0] j,
  output logic [15:0] k,
  output logic [15:0] l,
  output logic [15:0] m,
  output logic [15:0] n,
  output logic [15:0] o,
  output logic [15:0] p
);
  assign a = x + y;
  assign b = x - y;
  assign c = y - x;
  assign d = 16'h0001;
  assign e = 16'h0000;
  assign f = 16'hFFFF;
  assign g = 16'h0000 - x;
  assign h = 16'h0000 - y;
  assign i = ~x;
  assign j = ~y;
  assign k = x + 16'h0001;
  assign l = y + 16'h0001;
  assign m = x - 16'h0001;
  assign n = y - 16'h0001;
  assign o = x & y;
  assign p = x | y;
endmodule

module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        out_zero,
  output logic        out_neg,
  output logic        out_err,
  output logic        busy
);
`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic [15:0] mul_sum;
`else
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`endif

  state_t      state;
  logic [4:0]  op_lat;
  logic [15:0] x_lat, y_lat;
  logic [15:0] alu_x, alu_y;
  logic [15:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [15:0] r_i, r_j, r_k, r_l, r_m, r_n, r_o, r_p;
  logic [15:0] sel;

  // During MUL the adder output a computes acc + (x << cnt).
  always_comb begin
    alu_x = x_lat;
    alu_y = y_lat;
`ifdef ALU_SEQ_MUL_EN
    if (state == MUL) begin
      alu_x = acc;
      alu_y = x_lat << cnt;
    end
`endif
  end

  alu u_alu (
    .x(alu_x), .y(alu_y),
    .a(r_a), .b(r_b), .c(r_c), .d(r_d), .e(r_e), .f(r_f), .g(r_g), .h(r_h),
    .i(r_i), .j(r_j), .k(r_k), .l(r_l), .m(r_m), .n(r_n), .o(r_o), .p(r_p)
  );

  always_comb begin
    sel = 16'h0000;
    case (op_lat)
      5'd0:  sel = r_a;
      5'd1:  sel = r_b;
      5'd2:  sel = r_c;
      5'd3:  sel = r_d;
      5'd4:  sel = r_e;
      5'd5:  sel = r_f;
      5'd6:  sel = r_g;
      5'd7:  sel = r_h;
      5'd8:  sel = r_i;
      5'd9:  sel = r_j;
      5'd10: sel = r_k;
      5'd11: sel = r_l;
      5'd12: sel = r_m;
      5'd13: sel = r_n;
      5'd14: sel = r_o;
      5'd15: sel = r_p;
      default: sel = 16'h0000;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  assign mul_sum = y_lat[cnt] ? r_a : acc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_lat     <= 5'd0;
      x_lat      <= 16'h0000;
      y_lat      <= 16'h0000;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_err    <= 1'b0;
      busy       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc        <= 16'h0000;
      cnt        <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_lat   <= in_op;
            x_lat    <= in_x;
            y_lat    <= in_y;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= EXEC;
`ifdef ALU_SEQ_MUL_EN
            if (in_op == 5'd16) begin
              acc   <= 16'h0000;
              cnt   <= 4'd0;
              state <= MUL;
            end
`endif
          end
        end
        EXEC: begin
          // Illegal ops land on the default select (0), so zero follows naturally.
          out_result <= sel;
          out_zero   <= (sel == 16'h0000);
          out_neg    <= sel[15];
          out_err    <= op_lat[4];
          out_valid  <= 1'b1;
          state      <= DONE;
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          acc <= mul_sum;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            out_result <= mul_sum;
            out_zero   <= (mul_sum == 16'h0000);
            out_neg    <= mul_sum[15];
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
